logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined W-bit bitwise logic unit: successor to the single-function per-bit NAND gate array.
- Selects one of eight bitwise operations per transaction and carries the result through STAGES elastic pipeline registers.
- Uses a valid/ready handshake on both input and output, and produces a zero flag with each result.
- Sits in the ALU datapath beside the adder/shifter; results feed the ALU result mux.

Parameters:
- W, 32, operand/result width in bits (1..64).
- STAGES, 2, number of pipeline register stages (1..4); no-stall latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  A/B/op presented this cycle.
- in_ready  output  1  pipe accepts the input this cycle.
- op  input  3  operation select.
- A  input  W  operand A.
- B  input  W  operand B.
- out_valid  output  1  out/zero hold a valid result.
- out_ready  input  1  consumer accepts the result.
- out  output  W  result.
- zero  output  1  high when out is all zeros.
- parity  output  1  present only with LOGIC_UNIT_PARITY_EN; XOR-reduction of out.

Behaviour:
- Reset is asynchronous, effective immediately, independent of clk.
  - Every stage valid bit clears to 0, so out_valid=0.
  - out=0, zero=1, parity=0.
  - in_ready reads 1 as soon as rst deasserts.
  - Any transactions in flight are discarded and never reappear.
- op encoding, per bit i:
  - 000 AND, 001 OR, 010 XOR, 011 NAND (~(A&B)), 100 NOR, 101 XNOR.
  - 110 NOT A (B ignored), 111 PASS A.
- Op evaluation:
  - The op is evaluated combinationally at the input and captured into stage 0.
  - Later stages copy data unchanged.
  - zero is computed from the stage-0 result and carried alongside it.
- Input accept: in_valid && in_ready at a rising edge.
- Stage k (0..STAGES-1) holds {valid_k, data_k, zero_k}.
- Stage k loads from its upstream source when it is empty or its contents move forward that same cycle.
  - upstream source = input for k=0, stage k-1 otherwise.
  - moves forward = k is the last stage and out_ready=1, or stage k+1 loads.
- valid_k after a load = upstream valid; data is don't-care-stable when valid=0.
- Stage registers hold their value when not loading (no data change while out_valid && !out_ready).
- in_ready = !valid_0 || stage 0 moves forward.
  - Combinational through the stages from out_ready; no combinational in_valid->in_ready path.
- Outputs: out_valid = valid_{STAGES-1}; out and zero come from the last stage.
- Latency: a transaction accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (no stalls).
- Throughput: one result per cycle while out_ready=1.
- Full pipe:
  - STAGES results held with out_ready=0 gives in_ready=0.
  - in_valid is ignored; the input is not captured.
- Simultaneous drain and fill:
  - Full pipe with out_ready=1 and in_valid=1: one pops and one enters in the same cycle.
  - in_ready stays 1.
- Order: results leave in acceptance order; none are dropped or duplicated.
- Width rules: all operations are pure bitwise at W bits; no carry and no sign handling.

Optional Feature:
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined:
  - parity port exists and equals ^out, computed at stage 0 and carried with the data.
  - Reset value is 0.
- Undefined:
  - parity port and its registers are absent.
  - All other behaviour is identical.

Test Plan:
- W=8, STAGES=2, out_ready=1; A=0xF0, B=0xCC, op=011 for one cycle -> two edges later out=0x3F, zero=0, out_valid for exactly 1 cycle.
- Sweep all 8 ops with A=0xA5, B=0x0F -> 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0x5A, 0xA5 in order, back-to-back, 1 per cycle.
- A=0xFF, B=0xFF, op=010 -> out=0x00, zero=1; with LOGIC_UNIT_PARITY_EN, A=0x07, op=111 -> parity=1.
- Backpressure test:
  - Hold out_ready=0 and stream 3 inputs -> in_ready drops after 2 accepted; out holds the first result stable.
  - Release out_ready -> results emerge in order, third accepted on release cycle.
- Assert rst mid-stream, between clock edges, with 2 results in flight -> out_valid=0 and out=0 immediately; after release in_ready=1 and no stale result is ever emitted.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Pipelined W-bit bitwise logic unit with valid/ready on both ends and a zero flag.
// Define LOGIC_UNIT_PARITY_EN to add a parity output (XOR-reduction of out).
module logic_unit_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic         parity
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [W-1:0]      result;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] zero_q;
  logic [STAGES-1:0] load;
  logic [W-1:0]      data_q [STAGES];
`ifdef LOGIC_UNIT_PARITY_EN
  logic [STAGES-1:0] par_q;
`endif

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NAND: result = ~(A & B);
      OP_NOR:  result = ~(A | B);
      OP_XNOR: result = ~(A ^ B);
      OP_NOTA: result = ~A;
      OP_PASS: result = A;
      default: result = A;
    endcase
  end

  // A stage can load when the consumer pops or any stage at or after it is empty;
  // this closed form avoids a combinational chain through load itself.
  always_comb begin
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) load[k] = 1'b1;
      end
    end
  end

  // NOTE: the stage registers are few and out/zero must read 0/1 in reset, so all of
  // them are reset, not just the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      zero_q  <= '1;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking so each stage captures its upstream's pre-edge contents.
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= result;
          zero_q[0] <= ~|result;
`ifdef LOGIC_UNIT_PARITY_EN
          par_q[0]  <= ^result;
`endif
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            zero_q[k] <= zero_q[k-1];
`ifdef LOGIC_UNIT_PARITY_EN
            par_q[k]  <= par_q[k-1];
`endif
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = data_q[STAGES-1];
  assign zero      = zero_q[STAGES-1];
`ifdef LOGIC_UNIT_PARITY_EN
  assign parity    = par_q[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (W=8, STAGES=2): the driver queues expected
// results on accept, a negedge monitor pops and compares whenever a result is taken.
module tb_logic_unit_pipe;
  localparam int W      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic         parity;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         zero;
    logic         par;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  logic [W-1:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};

  logic_unit_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero)
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every result the consumer takes must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got 0x%0h expected no result", out);
      end else begin
        mon_e = q.pop_front();
        check("result", out, mon_e.data);
        check("zero", zero, mon_e.zero);
`ifdef LOGIC_UNIT_PARITY_EN
        check("parity", parity, mon_e.par);
`endif
      end
    end
  end

  // Called at posedge+1; holds the vector until accepted, returns at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] o, input logic [W-1:0] exp);
    int n;
    A = a; B = b; op = o; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      q.push_back('{data: exp, zero: (exp == '0), par: ^exp});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    time t0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; A = '0; B = '0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_zero", zero, 1);
`ifdef LOGIC_UNIT_PARITY_EN
    check("reset_parity", parity, 0);
`endif
    #12 rst = 1'b0;
    #1 check("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single NAND transaction: valid for exactly one cycle after the latency.
    send(8'hF0, 8'hCC, 3'b011, 8'h3F);
    in_valid = 1'b0;
    @(negedge clk); check("nand_not_yet_valid", out_valid, 0);
    @(negedge clk); check("nand_valid", out_valid, 1);
    @(negedge clk); check("nand_valid_one_cycle", out_valid, 0);
    @(posedge clk); #1;

    // All eight ops back to back, one accepted per cycle.
    t0 = $time;
    for (int i = 0; i < 8; i++) send(8'hA5, 8'h0F, 3'(i), sweep_exp[i]);
    check("sweep_rate_cycles", 32'(($time - t0) / 10), 8);
    in_valid = 1'b0;
    drain();

    send(8'hFF, 8'hFF, 3'b010, 8'h00);
`ifdef LOGIC_UNIT_PARITY_EN
    send(8'h07, 8'h00, 3'b111, 8'h07);
`endif
    in_valid = 1'b0;
    drain();

    // Backpressure: two fill the pipe, the third waits until out_ready returns.
    out_ready = 1'b0;
    send(8'h3C, 8'h0F, 3'b000, 8'h0C);
    send(8'h3C, 8'h0F, 3'b001, 8'h3F);
    A = 8'h3C; B = 8'h0F; op = 3'b010; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_stable", out, 8'h0C);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    if (in_ready) q.push_back('{data: 8'h33, zero: 1'b0, par: ^8'h33});
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with two results in flight.
    send(8'h11, 8'h22, 3'b001, 8'h33);
    send(8'h0F, 8'hF0, 3'b000, 8'h00);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out", out, 0);
    check("async_rst_zero", zero, 1);
    q.delete();
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_result", out_valid, 0);
    end

    // Pipe still works after reset.
    @(posedge clk); #1;
    send(8'hC3, 8'hFF, 3'b101, 8'hC3);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
